// File: rtl/mpeg_out_reader.sv
// Read-side front end for the output FIFO: pops bytes with 1-cycle read latency into a skid
// buffer and presents them as a valid/ready stream. Optional CRC-32 port: MPEG_OUT_CRC_EN.
module mpeg_out_reader #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n_200,
    input  logic [7:0]       mpeg_out,
    input  logic             mpeg_empty,
    output logic             mpeg_rd,
    input  logic             stream_end,
    input  logic [CNT_W-1:0] expected_cnt,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             done,
`ifdef MPEG_OUT_CRC_EN
    output logic [31:0]      crc_out,
`endif
    output logic             err_over
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = AW + 1;
    localparam logic [OW:0] LP_DEPTH = (OW + 1)'(DEPTH);

    logic [7:0]       r_buf [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [OW-1:0]    r_occ;
    logic             r_inflight;
    logic             r_done, r_err_over;
    logic [CNT_W-1:0] r_out_cnt, r_stall_cnt;

    logic       w_push, w_pop, w_over, w_done_set;
    logic [OW:0] w_pending;

    // Credit check counts the byte already in flight so its capture always has space.
    assign w_pending  = {1'b0, r_occ} + (OW + 1)'(r_inflight);
    assign mpeg_rd    = ~mpeg_empty & (w_pending < LP_DEPTH) & ~r_err_over;
    assign w_push     = r_inflight;
    assign out_valid  = (r_occ != '0);
    assign out_data   = r_buf[r_rd_ptr];
    assign w_pop      = out_valid & out_ready;
    assign w_over     = w_pop & stream_end & (r_out_cnt >= expected_cnt);
    assign w_done_set = stream_end & (r_out_cnt == expected_cnt) & (r_occ == '0) &
                        ~r_inflight & mpeg_empty & ~r_err_over;

    assign out_cnt   = r_out_cnt;
    assign stall_cnt = r_stall_cnt;
    assign done      = r_done;
    assign err_over  = r_err_over;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= mpeg_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n_200) begin
        if (!rst_n_200) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_inflight  <= 1'b0;
            r_out_cnt   <= '0;
            r_stall_cnt <= '0;
            r_done      <= 1'b0;
            r_err_over  <= 1'b0;
        end else begin
            r_inflight <= mpeg_rd;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
            if (w_pop && (r_out_cnt != '1)) begin
                r_out_cnt <= r_out_cnt + CNT_W'(1);
            end
            if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_over) begin
                r_err_over <= 1'b1;
            end
            if (w_done_set) begin
                r_done <= 1'b1;
            end
        end
    end

`ifdef MPEG_OUT_CRC_EN
    logic [31:0] r_crc;
    logic [31:0] w_crc_next;

    // Reflected CRC-32, LSB of each byte first.
    always_comb begin
        w_crc_next = r_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_crc_next[0] ^ out_data[i]) begin
                w_crc_next = (w_crc_next >> 1) ^ 32'hEDB8_8320;
            end else begin
                w_crc_next = w_crc_next >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_200) begin
        if (!rst_n_200) begin
            r_crc <= 32'hFFFF_FFFF;
        end else if (w_pop && !r_done) begin
            r_crc <= w_crc_next;
        end
    end

    assign crc_out = ~r_crc;
`endif

endmodule

// File: tb/tb_mpeg_out_reader.sv
// Self-checking bench for mpeg_out_reader: randomized FIFO/downstream stimulus against a
// queue-based reference model, plus literal checks for each scenario.
module tb_mpeg_out_reader;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n_200;
    logic [7:0]       mpeg_out;
    logic             mpeg_empty;
    logic             mpeg_rd;
    logic             stream_end;
    logic [CNT_W-1:0] expected_cnt;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             done;
    logic             err_over;
`ifdef MPEG_OUT_CRC_EN
    logic [31:0]      crc_out;
`endif

    mpeg_out_reader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n_200    (rst_n_200),
        .mpeg_out     (mpeg_out),
        .mpeg_empty   (mpeg_empty),
        .mpeg_rd      (mpeg_rd),
        .stream_end   (stream_end),
        .expected_cnt (expected_cnt),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_cnt      (out_cnt),
        .stall_cnt    (stall_cnt),
        .done         (done),
`ifdef MPEG_OUT_CRC_EN
        .crc_out      (crc_out),
`endif
        .err_over     (err_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: source FIFO contents and bytes popped but not yet accepted.
    logic [7:0]  src_q[$];
    logic [7:0]  sb_q[$];
    int          accepted, stalls;
    bit          infl, done_m, err_m, toggle_empty;
    logic [31:0] crc_m;
    int          cyc, first_rd, last_rd, first_valid, rd_cnt, first_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic model_reset();
        sb_q.delete();
        accepted    = 0;
        stalls      = 0;
        infl        = 1'b0;
        done_m      = 1'b0;
        err_m       = 1'b0;
        crc_m       = 32'hFFFF_FFFF;
        cyc         = 0;
        first_rd    = -1;
        last_rd     = -1;
        first_valid = -1;
        rd_cnt      = 0;
        first_acc   = -1;
    endtask

    task automatic assert_reset();
        #2;
        rst_n_200  = 1'b0;
        mpeg_empty = 1'b1;
        model_reset();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n_200 = 1'b1;
    endtask

    // One clock cycle: compare DUT against the model at the negedge, then advance both.
    task automatic step();
        bit         exp_rd, exp_valid, acc, do_pop, done_nxt, err_nxt;
        logic [7:0] b;
        b = 8'h00;
        mpeg_empty = (src_q.size() == 0) || (toggle_empty && cyc[0]);
        @(negedge clk);
        exp_rd    = !mpeg_empty && (sb_q.size() < DEPTH) && !err_m;
        exp_valid = sb_q.size() > int'(infl);
        chk("mpeg_rd", 32'(mpeg_rd), 32'(exp_rd));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("out_cnt", out_cnt, 32'(accepted));
        chk("stall_cnt", stall_cnt, 32'(stalls));
        chk("done", 32'(done), 32'(done_m));
        chk("err_over", 32'(err_over), 32'(err_m));
        if (exp_valid) chk("out_data", 32'(out_data), 32'(sb_q[0]));
`ifdef MPEG_OUT_CRC_EN
        chk("crc_out", crc_out, ~crc_m);
`endif
        acc      = exp_valid && out_ready;
        done_nxt = stream_end && (accepted == int'(expected_cnt)) && (sb_q.size() == 0) &&
                   !infl && mpeg_empty && !err_m;
        err_nxt  = acc && stream_end && (accepted >= int'(expected_cnt));
        if (exp_valid && first_valid < 0) first_valid = cyc;
        if (acc) begin
            if (!done_m) crc_m = crc_byte(crc_m, sb_q[0]);
            if (first_acc < 0) first_acc = int'(sb_q[0]);
            void'(sb_q.pop_front());
            accepted++;
        end
        if (exp_valid && !out_ready) stalls++;
        if (mpeg_rd === 1'b1) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        do_pop = (mpeg_rd === 1'b1) && (src_q.size() > 0);
        if (do_pop) begin
            b = src_q.pop_front();
            sb_q.push_back(b);
        end
        infl   = do_pop;
        done_m = done_m | done_nxt;
        err_m  = err_m | err_nxt;
        @(posedge clk);
        #1;
        mpeg_out = do_pop ? b : 8'($urandom);
        cyc++;
    endtask

    initial begin
        rst_n_200    = 1'b0;
        mpeg_out     = 8'h00;
        mpeg_empty   = 1'b1;
        stream_end   = 1'b0;
        expected_cnt = '0;
        out_ready    = 1'b0;
        toggle_empty = 1'b0;
        model_reset();
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mpeg_rd", 32'(mpeg_rd), 32'd0);
        chk("rst_out_cnt", out_cnt, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;

        // Basic stream
        for (int i = 0; i < 10; i++) src_q.push_back(8'(i));
        out_ready    = 1'b1;
        expected_cnt = 32'd10;
        stream_end   = 1'b1;
        rst_n_200    = 1'b1;
        repeat (20) step();
        chk("basic_latency", 32'(first_valid - first_rd), 32'd2);
        chk("basic_rd_cnt", 32'(rd_cnt), 32'd10);
        chk("basic_rd_span", 32'(last_rd - first_rd), 32'd9);
        chk("basic_out_cnt", out_cnt, 32'd10);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_stall", stall_cnt, 32'd0);

        // Backpressure
        assert_reset();
        src_q.delete();
        for (int i = 0; i < 20; i++) src_q.push_back(8'(8'h40 + i));
        out_ready    = 1'b0;
        expected_cnt = 32'd20;
        release_reset();
        repeat (8) step();
        chk("bp_rd_cnt", 32'(rd_cnt), 32'd4);
        out_ready = 1'b1;
        repeat (40) step();
        chk("bp_stall", stall_cnt, 32'd6);
        chk("bp_out_cnt", out_cnt, 32'd20);
        chk("bp_done", 32'(done), 32'd1);

        // Intermittent empty with random backpressure
        assert_reset();
        src_q.delete();
        for (int i = 0; i < 30; i++) src_q.push_back(8'($urandom));
        expected_cnt = 32'd30;
        toggle_empty = 1'b1;
        release_reset();
        for (int n = 0; n < 400 && !done_m; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        repeat (2) step();
        toggle_empty = 1'b0;
        chk("int_done", 32'(done), 32'd1);
        chk("int_out_cnt", out_cnt, 32'd30);

        // Over-delivery
        assert_reset();
        src_q.delete();
        for (int i = 0; i < 7; i++) src_q.push_back(8'(8'hA0 + i));
        expected_cnt = 32'd5;
        out_ready    = 1'b1;
        release_reset();
        repeat (20) step();
        chk("over_err", 32'(err_over), 32'd1);
        chk("over_done", 32'(done), 32'd0);
        chk("over_out_cnt", out_cnt, 32'd7);

        // Async reset mid-stream with occ=3
        assert_reset();
        src_q.delete();
        for (int i = 0; i < 10; i++) src_q.push_back(8'(8'h70 + i));
        expected_cnt = 32'd6;
        stream_end   = 1'b0;
        out_ready    = 1'b0;
        release_reset();
        repeat (4) step();
        chk("ar_valid_before", 32'(out_valid), 32'd1);
        assert_reset();
        #1;
        chk("ar_valid_async", 32'(out_valid), 32'd0);
        chk("ar_out_cnt", out_cnt, 32'd0);
        stream_end = 1'b1;
        out_ready  = 1'b1;
        release_reset();
        repeat (20) step();
        chk("ar_first_byte", 32'(first_acc), 32'h74);
        chk("ar_out_cnt_end", out_cnt, 32'd6);
        chk("ar_done", 32'(done), 32'd1);

`ifdef MPEG_OUT_CRC_EN
        // CRC over "123456789"
        assert_reset();
        src_q.delete();
        for (int i = 0; i < 9; i++) src_q.push_back(8'(8'h31 + i));
        expected_cnt = 32'd9;
        release_reset();
        repeat (20) step();
        chk("crc_check", crc_out, 32'hCBF4_3926);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
